// File: rtl/seq_divider_pkg.sv
// Shared calc definitions for the sequential divider: state encoding,
// default widths and the special-case quotient constants.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  localparam logic [DW_DEF-1:0] DZ_QUO  = '1;
  localparam logic [DW_DEF-1:0] OVF_QUO = {1'b1, {(DW_DEF-1){1'b0}}};

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude and keep or restore the partial remainder.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   prem,
  input  logic          in_bit,
  input  logic [VW-1:0] dvs_mag,
  output logic [VW:0]   prem_next,
  output logic          q_bit
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] diff;

  always_comb begin
    shifted = {prem, in_bit};
    diff    = shifted - {2'b00, dvs_mag};
    q_bit   = (shifted >= {2'b00, dvs_mag});
    // The kept remainder is always below the divisor, so the top bit drops safely.
    prem_next = (VW+1)'(q_bit ? diff : shifted);
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/busy/done handshake, signed or
// unsigned operands, divide-by-zero and signed-overflow flags.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sgn,
  input  logic [DW-1:0] dvd,
  input  logic [VW-1:0] dvs,
  output logic [DW-1:0] quo,
  output logic [VW-1:0] rem,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic          ovf
);

  localparam int CW = $clog2(DW);

  state_t        state;
  logic          sgn_r;
  logic          qs;
  logic          rs;
  logic          dz_pend;
  logic [DW-1:0] shreg;
  logic [VW-1:0] dvs_mag_r;
  logic [VW:0]   prem;
  logic [CW-1:0] cnt;

  logic          dvd_neg;
  logic          dvs_neg;
  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;
  logic [VW:0]   prem_next;
  logic          q_bit;
  logic [VW-1:0] r_mag;
  logic [DW-1:0] q_fix;
  logic [VW-1:0] r_fix;
  logic          ovf_c;

  always_comb begin
    dvd_neg = sgn & dvd[DW-1];
    dvs_neg = sgn & dvs[VW-1];
    dvd_mag = dvd_neg ? -dvd : dvd;
    dvs_mag = dvs_neg ? -dvs : dvs;
  end

  div_step #(.VW(VW)) u_step (
    .prem      (prem),
    .in_bit    (shreg[DW-1]),
    .dvs_mag   (dvs_mag_r),
    .prem_next (prem_next),
    .q_bit     (q_bit)
  );

  // shreg starts as the dividend magnitude and ends as the quotient magnitude.
  always_comb begin
    r_mag = VW'(prem);
    q_fix = qs ? -shreg : shreg;
    r_fix = rs ? -r_mag : r_mag;
    ovf_c = sgn_r & ~qs & shreg[DW-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sgn_r     <= 1'b0;
      qs        <= 1'b0;
      rs        <= 1'b0;
      dz_pend   <= 1'b0;
      shreg     <= '0;
      dvs_mag_r <= '0;
      prem      <= '0;
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            prem <= '0;
            if (dvs == '0) begin
              dz_pend <= 1'b1;
              state   <= FIX;
            end else begin
              sgn_r     <= sgn;
              qs        <= dvd_neg ^ dvs_neg;
              rs        <= dvd_neg;
              shreg     <= dvd_mag;
              dvs_mag_r <= dvs_mag;
              state     <= DIV;
            end
          end
        end
        DIV: begin
          prem  <= prem_next;
          shreg <= {shreg[DW-2:0], q_bit};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(DW-1)) state <= FIX;
        end
        FIX: begin
          if (dz_pend) begin
            quo <= DZ_QUO;
            rem <= '0;
            dz  <= 1'b1;
            ovf <= 1'b0;
          end else if (ovf_c) begin
            quo <= OVF_QUO;
            rem <= '0;
            dz  <= 1'b0;
            ovf <= 1'b1;
          end else begin
            quo <= q_fix;
            rem <= r_fix;
            dz  <= 1'b0;
            ovf <= 1'b0;
          end
          dz_pend <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring divider for the signed calculator datapath, the inverse operation to the gate-level array multiplier. It takes an 8-bit dividend and a 4-bit divisor, unsigned or two's-complement signed. It returns an 8-bit quotient and a 4-bit remainder after a fixed iteration count. A start/busy/done handshake connects it to the calculator control.

## Interface
- DW, 8, dividend and quotient width
- VW, 4, divisor and remainder width (VW < DW)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sgn  in  1  1 = operands two's complement, 0 = unsigned; latched with start
- dvd  in  DW  dividend; latched with start
- dvs  in  VW  divisor; latched with start
- quo  out  DW  quotient, registered
- rem  out  VW  remainder, registered
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when quo/rem/flags are valid
- dz  out  1  divide-by-zero flag, valid with done
- ovf  out  1  signed overflow flag, valid with done

## Operation
- States: IDLE, DIV, FIX.
- IDLE, start=1, dvs!=0:
  - latch sgn and operand magnitudes (negate when sgn and MSB set).
  - latch quotient sign = sa^sb and remainder sign = sa.
  - clear partial remainder (VW+1 bits) and iteration counter.
  - go to DIV.
- IDLE, start=1, dvs==0: go to FIX with dz pending; no iterations.
- DIV, one restoring step per cycle:
  - shift partial remainder left, bringing in the dividend MSB.
  - trial-subtract the divisor magnitude.
  - if result >= 0, keep it and shift in quotient bit 1; else restore and shift in 0.
  - after DW steps, go to FIX.
- FIX:
  - apply signs (truncation toward zero; remainder takes the dividend sign).
  - write quo, rem, dz and ovf; pulse done; return to IDLE.
- Divide by zero: quo = all ones, rem = 0, dz = 1, ovf = 0.
- Overflow: sgn=1 and the positive quotient magnitude exceeds 2^(DW-1)-1 (only -128 / -1). Then quo = 8'h80, rem = 0, ovf = 1.
- Unsigned mode never sets ovf.
- Signed remainder magnitude is at most 7, so it always fits in VW bits.
- quo, rem, dz and ovf hold their values until the FIX of the next operation.
- start while busy is ignored. Input changes after the latch edge have no effect.

## Timing
- Reset values: state IDLE, quo=0, rem=0, busy=0, done=0, dz=0, ovf=0. Internal registers cleared.
- Let E0 be the edge that samples start in IDLE.
- busy rises after E0 and falls after the edge that writes FIX results.
- Normal operation:
  - iterations run on edges E1..E_DW.
  - the FIX write happens on E_(DW+1), so done is high for the cycle after E_(DW+1) (DW+1 edges of latency).
- Divide by zero: FIX write on E1; done is high for the cycle after E1.
- done and busy are never high together.
- The state is IDLE in the done cycle, so start asserted during done is accepted (back-to-back, no dead cycle).
- rst asserted at any time, including mid-DIV, forces all reset values immediately. No done is produced for the aborted operation.

## Structure
- Shared calc package holds:
  - state encoding constants (IDLE, DIV, FIX).
  - default widths DW=8 and VW=4.
  - the divide-by-zero quotient constant (all ones) and the signed overflow quotient constant (8'h80).
- One sub-module, div_step: purely combinational shift/trial-subtract/restore producing the next partial remainder and the quotient bit. It is instantiated once and reused every DIV cycle.
- Sign conditioning (magnitude and re-negation) stays in the top level.

## Test plan
- Unsigned 100/7 (sgn=0, dvd=8'd100, dvs=4'd7) -> quo=8'd14, rem=4'd2, dz=0, ovf=0, done exactly 9 edges after E0, busy high 9 cycles.
- Signed -100/7 (dvd=8'h9C, dvs=4'h7) -> quo=8'hF2 (-14), rem=4'hE (-2). Signed 100/-7 -> quo=8'hF2, rem=4'h2.
- Signed -128/-1 (dvd=8'h80, dvs=4'hF) -> ovf=1, quo=8'h80, rem=0. Unsigned 255/15 -> quo=8'd17, rem=0, ovf=0.
- Divide by zero 55/0 -> dz=1, quo=8'hFF, rem=0, done one edge after E0. A following 9/3 start in the done cycle is accepted -> quo=3, rem=0, dz=0.
- rst pulse at iteration 4 of 200/9 -> all outputs 0 and IDLE immediately, no done.
  - start during busy with different operands is ignored.
  - a fresh 200/9 then gives quo=8'd22, rem=4'd2.
